// File: rtl/full_adder.sv
// Registered ripple-carry adder built from 1-bit full-adder cells.
// WIDTH=1 is the classic full adder; wider settings chain cells through k[].
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             out_valid
);

    // Handshake: in_valid qualifies a/b/cin on a rising edge; there is no
    // backpressure, and out_valid is high for exactly the cycle after each
    // accepted edge. With in_valid low, s/c/ovf keep their last result.

    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum_nxt;

    assign k[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_nxt[i] = a[i] ^ b[i] ^ k[i];
        assign k[i+1]     = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            c         <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s   <= sum_nxt;
                c   <= k[WIDTH];
                // Carry into the MSB cell vs. carry out of it.
                ovf <= k[WIDTH] ^ k[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1, 8 and 32 sharing one clock/reset.
module tb_full_adder;

  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cyc   = '0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- DUT signals ----------------
  logic        a_w1, b_w1, cin_w1, iv_w1, s_w1, c_w1, ovf_w1, ov_w1;
  logic [7:0]  a_w8, b_w8, s_w8;
  logic        cin_w8, iv_w8, c_w8, ovf_w8, ov_w8;
  logic [31:0] a_w32, b_w32, s_w32;
  logic        cin_w32, iv_w32, c_w32, ovf_w32, ov_w32;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a_w1), .b(b_w1), .cin(cin_w1), .in_valid(iv_w1),
    .s(s_w1), .c(c_w1), .ovf(ovf_w1), .out_valid(ov_w1));

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a_w8), .b(b_w8), .cin(cin_w8), .in_valid(iv_w8),
    .s(s_w8), .c(c_w8), .ovf(ovf_w8), .out_valid(ov_w8));

  full_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .a(a_w32), .b(b_w32), .cin(cin_w32), .in_valid(iv_w32),
    .s(s_w32), .c(c_w32), .ovf(ovf_w32), .out_valid(ov_w32));

  // ---------------- scoreboard ----------------
  // Entry layout: {expected cycle, c, ovf, s}
  logic [CW+2:0]  exp_q1[$];
  logic [CW+9:0]  exp_q8[$];
  logic [CW+33:0] exp_q32[$];
  logic [CW+2:0]  e1;
  logic [CW+9:0]  e8;
  logic [CW+33:0] e32;
  logic [2:0]     held1  = '0;
  logic [9:0]     held8  = '0;
  logic [33:0]    held32 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_w1", 64'({ov_w1, c_w1, ovf_w1, s_w1}), 64'd0);
    end else if (ov_w1) begin
      if (exp_q1.size() == 0) chk("spurious_w1", 64'd1, 64'd0);
      else begin
        e1 = exp_q1.pop_front();
        chk("latency_w1", 64'(cyc), 64'(e1[CW+2:3]));
        chk("result_w1", 64'({c_w1, ovf_w1, s_w1}), 64'(e1[2:0]));
        held1 = e1[2:0];
      end
    end else begin
      chk("hold_w1", 64'({c_w1, ovf_w1, s_w1}), 64'(held1));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_w8", 64'({ov_w8, c_w8, ovf_w8, s_w8}), 64'd0);
    end else if (ov_w8) begin
      if (exp_q8.size() == 0) chk("spurious_w8", 64'd1, 64'd0);
      else begin
        e8 = exp_q8.pop_front();
        chk("latency_w8", 64'(cyc), 64'(e8[CW+9:10]));
        chk("result_w8", 64'({c_w8, ovf_w8, s_w8}), 64'(e8[9:0]));
        held8 = e8[9:0];
      end
    end else begin
      chk("hold_w8", 64'({c_w8, ovf_w8, s_w8}), 64'(held8));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_w32", 64'({ov_w32, c_w32, ovf_w32, s_w32}), 64'd0);
    end else if (ov_w32) begin
      if (exp_q32.size() == 0) chk("spurious_w32", 64'd1, 64'd0);
      else begin
        e32 = exp_q32.pop_front();
        chk("latency_w32", 64'(cyc), 64'(e32[CW+33:34]));
        chk("result_w32", 64'({c_w32, ovf_w32, s_w32}), 64'(e32[33:0]));
        held32 = e32[33:0];
      end
    end else begin
      chk("hold_w32", 64'({c_w32, ovf_w32, s_w32}), 64'(held32));
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; the result appears on the next cycle.
  task automatic push1(input logic ta, tb_, tc, es, ec, eo);
    a_w1 = ta; b_w1 = tb_; cin_w1 = tc; iv_w1 = 1'b1;
    exp_q1.push_back({cyc + 32'd1, ec, eo, es});
  endtask

  task automatic push8(input logic [7:0] ta, tb_, input logic tc,
                       input logic [7:0] es, input logic ec, eo);
    a_w8 = ta; b_w8 = tb_; cin_w8 = tc; iv_w8 = 1'b1;
    exp_q8.push_back({cyc + 32'd1, ec, eo, es});
  endtask

  task automatic push32(input logic [31:0] ta, tb_, input logic tc,
                        input logic [31:0] es, input logic ec, eo);
    a_w32 = ta; b_w32 = tb_; cin_w32 = tc; iv_w32 = 1'b1;
    exp_q32.push_back({cyc + 32'd1, ec, eo, es});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    iv_w1 = 1'b0; iv_w8 = 1'b0; iv_w32 = 1'b0;
  endtask

  task automatic flush_all();
    exp_q1.delete(); exp_q8.delete(); exp_q32.delete();
    held1 = '0; held8 = '0; held32 = '0;
  endtask

  // Hand-computed WIDTH=1 truth table indexed by {a,b,cin}
  logic [1:0] cs_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  logic       ov_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  idx;
    logic        ra1, rb1, rc1;
    logic [1:0]  sum2;
    logic [7:0]  ra8, rb8;
    logic [8:0]  sum9;
    logic [31:0] ra32, rb32;
    logic [32:0] sum33;
    logic        rc, rv;

    a_w1 = 1'b1; b_w1 = 1'b1; cin_w1 = 1'b1; iv_w1 = 1'b1;
    a_w8 = 8'h01; b_w8 = 8'h01; cin_w8 = 1'b1; iv_w8 = 1'b1;
    a_w32 = 32'h1; b_w32 = 32'h1; cin_w32 = 1'b1; iv_w32 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    iv_w8 = 1'b0; iv_w32 = 1'b0;
    push1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();

    push1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    push1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); step();
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      push1(idx[2], idx[1], idx[0], cs_tab[i][0], cs_tab[i][1], ov_tab[i]);
      step();
    end

    push1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); step();
    a_w1 = 1'b0; b_w1 = 1'b0; cin_w1 = 1'b0;
    step(); step();

    push8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); step();
    push8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); step();
    push8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0); step();
    push32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0); step();
    push32(32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1); step();

    // Async reset while a stream is in flight
    repeat (3) begin
      push8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      step();
    end
    push8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    flush_all();
    #1;
    chk("async_rst_w8", 64'({ov_w8, c_w8, ovf_w8, s_w8}), 64'd0);
    step();
    rst_n = 1'b1;
    push8(8'h03, 8'h04, 1'b1, 8'h08, 1'b0, 1'b0);
    step(); step();

    // Random traffic; overflow modelled with the sign rule
    for (int n = 0; n < 1000; n++) begin
      ra1 = 1'($urandom_range(0, 1)); rb1 = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1)); rv = ($urandom_range(0, 3) != 0);
      if (rv) begin
        sum2 = 2'(ra1) + 2'(rb1) + 2'(rc);
        push1(ra1, rb1, rc, sum2[0], sum2[1], (ra1 == rb1) && (sum2[0] != ra1));
      end else begin
        a_w1 = ra1; b_w1 = rb1; cin_w1 = rc;
      end

      ra8 = 8'($urandom); rb8 = 8'($urandom);
      rc1 = 1'($urandom_range(0, 1)); rv = ($urandom_range(0, 3) != 0);
      if (rv) begin
        sum9 = 9'(ra8) + 9'(rb8) + 9'(rc1);
        push8(ra8, rb8, rc1, sum9[7:0], sum9[8], (ra8[7] == rb8[7]) && (sum9[7] != ra8[7]));
      end else begin
        a_w8 = ra8; b_w8 = rb8; cin_w8 = rc1;
      end

      ra32 = $urandom; rb32 = $urandom;
      rc = 1'($urandom_range(0, 1)); rv = ($urandom_range(0, 3) != 0);
      if (rv) begin
        sum33 = 33'(ra32) + 33'(rb32) + 33'(rc);
        push32(ra32, rb32, rc, sum33[31:0], sum33[32],
               (ra32[31] == rb32[31]) && (sum33[31] != ra32[31]));
      end else begin
        a_w32 = ra32; b_w32 = rb32; cin_w32 = rc;
      end
      step();
    end

    step(); step();
    chk("drain_w1", 64'(exp_q1.size()), 64'd0);
    chk("drain_w8", 64'(exp_q8.size()), 64'd0);
    chk("drain_w32", 64'(exp_q32.size()), 64'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
